// File: rtl/task_8_deserializer_if.sv
// task_8_deserializer_if: byte stream in, frame out with valid/ack, error and busy status
interface task_8_deserializer_if #(parameter int BYTES = 16);
  logic [7:0] i_data;
  logic i_valid;
  logic i_last;
  logic o_ready;
  logic [8*BYTES-1:0] o_data;
  logic o_valid;
  logic i_ack;
  logic o_error;
  logic o_busy;
  modport master (output i_data, i_valid, i_last, i_ack, input o_ready, o_data, o_valid, o_error, o_busy);
  modport slave (input i_data, i_valid, i_last, i_ack, output o_ready, o_data, o_valid, o_error, o_busy);
endinterface

// File: rtl/task_8_deserializer.sv
// task_8_deserializer: packs BYTES stream bytes (first byte in MSBs) into one frame held until acked.
// Define TASK_8_DESER_LEN_CHECK_EN to enforce packet length via i_last, with DRAIN and o_error.
module task_8_deserializer #(
  parameter int BYTES = 16,
  parameter int CNT_W = $clog2(BYTES)
) (
  input logic i_clk,
  input logic i_rst,
  task_8_deserializer_if.slave s
);
  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
`ifdef TASK_8_DESER_LEN_CHECK_EN
  localparam logic [1:0] DRAIN = 2'd2;
  logic error;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic [8*BYTES-1:0] data;
  assign s.o_ready = state != HOLD;
  assign s.o_valid = state == HOLD;
  assign s.o_busy = state != COLLECT || cnt != '0;
  assign s.o_data = data;
`ifdef TASK_8_DESER_LEN_CHECK_EN
  assign s.o_error = error;
`else
  assign s.o_error = 1'b0;
`endif
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= COLLECT;
      cnt <= '0;
      data <= '0;
`ifdef TASK_8_DESER_LEN_CHECK_EN
      error <= 1'b0;
`endif
    end else begin
`ifdef TASK_8_DESER_LEN_CHECK_EN
      error <= 1'b0;
`endif
      if (state == HOLD) begin
        if (s.i_ack) state <= COLLECT;
      end
`ifdef TASK_8_DESER_LEN_CHECK_EN
      else if (state == DRAIN) begin
        if (s.i_valid && s.i_last) begin
          error <= 1'b1;
          state <= COLLECT;
        end
      end
`endif
      else if (s.i_valid) begin
        data <= {data[8*BYTES-9:0], s.i_data};
`ifdef TASK_8_DESER_LEN_CHECK_EN
        cnt <= (cnt == LAST || s.i_last) ? '0 : cnt + 1'b1;
        if (cnt == LAST) state <= s.i_last ? HOLD : DRAIN;
        else if (s.i_last) error <= 1'b1;
`else
        cnt <= cnt == LAST ? '0 : cnt + 1'b1;
        if (cnt == LAST) state <= HOLD;
`endif
      end
    end
  end
endmodule

// File: tb/tb_task_8_deserializer.sv
// tb_task_8_deserializer: randomized and directed checks against a byte-queue reference model.
module tb_task_8_deserializer;
  localparam int B = 16;
`ifdef TASK_8_DESER_LEN_CHECK_EN
  localparam bit LEN = 1'b1;
`else
  localparam bit LEN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int passed = 0;
  task_8_deserializer_if #(.BYTES(B)) bus ();
  task_8_deserializer #(.BYTES(B)) dut (.i_clk(clk), .i_rst(rst), .s(bus));
  always #5 clk = ~clk;
  logic [7:0] hist[$];
  bit m_hold, m_drain, m_err;
  int m_n;
  function automatic void model_reset();
    hist = {};
    repeat (B) hist.push_back(8'h00);
    m_hold = 0;
    m_drain = 0;
    m_err = 0;
    m_n = 0;
  endfunction
  function automatic void model_step(logic [7:0] d, bit v, bit l, bit a);
    m_err = 0;
    if (m_hold) begin
      if (a) m_hold = 0;
    end else if (m_drain) begin
      if (v && l) begin
        m_drain = 0;
        m_err = 1;
      end
    end else if (v) begin
      hist.push_back(d);
      void'(hist.pop_front());
      m_n++;
      if (m_n == B) begin
        m_n = 0;
        if (!LEN || l) m_hold = 1;
        else m_drain = 1;
      end else if (LEN && l) begin
        m_n = 0;
        m_err = 1;
      end
    end
  endfunction
  function automatic logic [8*B+3:0] expv();
    logic [8*B-1:0] d;
    d = '0;
    foreach (hist[i]) d[8*(B-1-i) +: 8] = hist[i];
    return {!m_hold, m_hold, m_hold || m_drain || m_n != 0, m_err, d};
  endfunction
  function automatic logic [8*B+3:0] actv();
    return {bus.o_ready, bus.o_valid, bus.o_busy, bus.o_error, bus.o_data};
  endfunction
  task automatic cycle(input logic [7:0] d, input bit v, input bit l, input bit a);
    bus.i_data = d;
    bus.i_valid = v;
    bus.i_last = l;
    bus.i_ack = a;
    @(posedge clk);
    model_step(d, v, l, a);
    #1;
  endtask
  task automatic test_reset();
    bus.i_data = 0;
    bus.i_valid = 0;
    bus.i_last = 0;
    bus.i_ack = 0;
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (actv() !== {1'b1, 1'b0, 1'b0, 1'b0, {8*B{1'b0}}}) $display("FAIL reset_held got %h exp %h", actv(), {4'b1000, {8*B{1'b0}}});
    else passed++;
    rst = 0;
    cycle(8'h00, 0, 0, 0);
    checks++;
    if (actv() !== expv()) $display("FAIL reset_release got %h exp %h", actv(), expv());
    else passed++;
  endtask
  task automatic test_basic();
    for (int i = 0; i < B; i++) begin
      cycle(8'(i), 1, i == B - 1, 1);
      checks++;
      if (actv() !== expv()) $display("FAIL basic byte %0d got %h exp %h", i, actv(), expv());
      else passed++;
    end
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_error !== 1'b0 || bus.o_data !== 128'h000102030405060708090A0B0C0D0E0F)
      $display("FAIL basic_frame got v=%b e=%b d=%h exp v=1 e=0 d=000102030405060708090a0b0c0d0e0f", bus.o_valid, bus.o_error, bus.o_data);
    else passed++;
    cycle(8'h00, 0, 0, 1);
    checks++;
    if (actv() !== expv() || bus.o_valid !== 1'b0) $display("FAIL basic_release got %h exp %h", actv(), expv());
    else passed++;
  endtask
  task automatic test_hold();
    for (int i = 0; i < B; i++) cycle(8'h40 + 8'(i), 1, i == B - 1, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(8'hAA, 1, 0, 0);
      checks++;
      if (actv() !== expv() || bus.o_ready !== 1'b0 || bus.o_valid !== 1'b1) $display("FAIL hold_stall %0d got %h exp %h", i, actv(), expv());
      else passed++;
    end
    cycle(8'hAA, 1, 0, 1);
    checks++;
    if (actv() !== expv() || bus.o_ready !== 1'b1) $display("FAIL hold_ack got %h exp %h", actv(), expv());
    else passed++;
    cycle(8'hAA, 1, 0, 0);
    checks++;
    if (actv() !== expv() || bus.o_busy !== 1'b1) $display("FAIL hold_next_byte0 got %h exp %h", actv(), expv());
    else passed++;
    for (int i = 1; i < B; i++) cycle(8'(i), 1, i == B - 1, 1);
    checks++;
    if (bus.o_data !== 128'hAA0102030405060708090A0B0C0D0E0F) $display("FAIL hold_frame got %h exp aa0102030405060708090a0b0c0d0e0f", bus.o_data);
    else passed++;
    cycle(8'h00, 0, 0, 1);
  endtask
  task automatic test_length();
    int errs = 0, vals = 0;
    logic [7:0] sp[3] = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) begin
      cycle(sp[i], 1, i == 2, 1);
      errs += bus.o_error;
      vals += bus.o_valid;
      checks++;
      if (actv() !== expv()) $display("FAIL short byte %0d got %h exp %h", i, actv(), expv());
      else passed++;
    end
    cycle(8'h00, 0, 0, 1);
    errs += bus.o_error;
    checks++;
    if (errs !== (LEN ? 1 : 0) || vals !== 0) $display("FAIL short_flags got err=%0d val=%0d exp err=%0d val=0", errs, vals, LEN ? 1 : 0);
    else passed++;
    for (int i = 0; i < (LEN ? B : B - 3); i++) begin
      cycle(8'h10 + 8'(i), 1, LEN && i == B - 1, 1);
      checks++;
      if (actv() !== expv()) $display("FAIL after_short byte %0d got %h exp %h", i, actv(), expv());
      else passed++;
    end
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== (LEN ? 128'h101112131415161718191A1B1C1D1E1F : 128'h112233101112131415161718191A1B1C))
      $display("FAIL after_short_frame got v=%b d=%h", bus.o_valid, bus.o_data);
    else passed++;
    cycle(8'h00, 0, 0, 1);
    if (LEN) begin
      errs = 0;
      vals = 0;
      for (int i = 0; i < 18; i++) begin
        cycle(8'h50 + 8'(i), 1, i == 17, 1);
        errs += bus.o_error;
        vals += bus.o_valid;
        checks++;
        if (actv() !== expv()) $display("FAIL long byte %0d got %h exp %h", i, actv(), expv());
        else passed++;
      end
      checks++;
      if (errs !== 1 || vals !== 0 || bus.o_error !== 1'b1 || bus.o_busy !== 1'b0) $display("FAIL long_flags got err=%0d val=%0d busy=%b exp err=1 val=0 busy=0", errs, vals, bus.o_busy);
      else passed++;
      cycle(8'h00, 0, 0, 1);
      checks++;
      if (bus.o_error !== 1'b0) $display("FAIL long_err_pulse got %b exp 0", bus.o_error);
      else passed++;
    end
  endtask
  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) cycle(8'hE0 + 8'(i), 1, 0, 0);
    bus.i_valid = 0;
    #3 rst = 1;
    #1 model_reset();
    checks++;
    if (actv() !== expv() || bus.o_busy !== 1'b0 || bus.o_data !== '0) $display("FAIL async_reset got %h exp %h", actv(), expv());
    else passed++;
    #1 rst = 0;
    for (int i = 0; i < B; i++) cycle(8'h20 + 8'(i), 1, i == B - 1, 1);
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 128'h202122232425262728292A2B2C2D2E2F) $display("FAIL after_reset_frame got v=%b d=%h", bus.o_valid, bus.o_data);
    else passed++;
    cycle(8'h00, 0, 0, 1);
  endtask
  task automatic test_gaps();
    for (int i = 0; i < 2 * B - 1; i++) begin
      cycle(8'h30 + 8'(i / 2), i % 2 == 0, i == 2 * B - 2, 1);
      checks++;
      if (actv() !== expv()) $display("FAIL gaps cyc %0d got %h exp %h", i, actv(), expv());
      else passed++;
    end
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 128'h303132333435363738393A3B3C3D3E3F) $display("FAIL gaps_frame got v=%b d=%h", bus.o_valid, bus.o_data);
    else passed++;
    cycle(8'h00, 0, 0, 1);
  endtask
  task automatic test_random();
    for (int p = 0; p < 6; p++) begin
      logic [7:0] pkt[B];
      logic [8*B-1:0] want;
      int idx = 0, guard = 0;
      bit v, acc, seen = 0;
      foreach (pkt[i]) pkt[i] = 8'($urandom);
      foreach (pkt[i]) want[8*(B-1-i) +: 8] = pkt[i];
      while ((idx < B || m_hold) && guard < 300) begin
        v = idx < B && $urandom_range(9) < 7;
        acc = v && !m_hold;
        cycle(idx < B ? pkt[idx] : 8'h00, v, idx == B - 1, $urandom_range(1) == 1);
        if (acc) idx++;
        guard++;
        checks++;
        if (actv() !== expv()) $display("FAIL random pkt %0d cyc %0d got %h exp %h", p, guard, actv(), expv());
        else passed++;
        if (bus.o_valid === 1'b1 && !seen) begin
          seen = 1;
          checks++;
          if (bus.o_data !== want) $display("FAIL random_frame pkt %0d got %h exp %h", p, bus.o_data, want);
          else passed++;
        end
      end
      if (guard >= 300) begin
        checks++;
        $display("FAIL random_timeout pkt %0d got idx=%0d exp %0d", p, idx, B);
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_length();
    test_async_reset();
    test_gaps();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/task_8_deserializer.md
# task_8_deserializer

Byte-stream-to-parallel deserializer for the task 8 datapath. It is the receive-side counterpart of the task 8 serializer. It accepts a valid/ready/last byte stream and assembles `BYTES` bytes into one wide word, first byte in the MSBs. It presents the word to a downstream consumer with a valid/ack handshake. With length checking enabled, it also rejects packets whose length differs from `BYTES`.

## Interface
Parameters:
- `BYTES`, default 16: bytes per frame. Must be ≥ 2.
- `CNT_W`, default `$clog2(BYTES)`: byte-counter width. Derived; do not override.

Ports:
- `i_clk`, input, 1: clock. All state changes on the rising edge.
- `i_rst`, input, 1: asynchronous, active-high reset.
- `i_data`, input, 8: stream byte.
- `i_valid`, input, 1: `i_data` is valid.
- `i_last`, input, 1: current byte is the last byte of the packet.
- `o_ready`, output, 1: block can accept a byte.
- `o_data`, output, 8*`BYTES`: assembled frame. Byte 0 is in `[8*BYTES-1 -: 8]`.
- `o_valid`, output, 1: `o_data` holds a complete frame.
- `i_ack`, input, 1: consumer takes the frame.
- `o_error`, output, 1: one-cycle pulse on a length error.
- `o_busy`, output, 1: a packet is in progress or a frame is held.

## Operation
- A byte is accepted when `i_valid && o_ready`.
- Each accepted byte shifts into `o_data`: `o_data <= {o_data[8*BYTES-9:0], i_data}`.
- The byte counter `cnt` increments per accepted byte.
- States:
  - COLLECT: `o_ready=1`.
    - Accept with `cnt==BYTES-1` and `i_last=1` → HOLD, `cnt←0`.
    - Accept with `cnt<BYTES-1` and `i_last=1` → short packet: pulse `o_error`, `cnt←0`, stay in COLLECT. The partial `o_data` is not presented.
    - Accept with `cnt==BYTES-1` and `i_last=0` → DRAIN, `cnt←0`.
  - HOLD: `o_ready=0`, `o_valid=1`.
    - `i_ack=1` → COLLECT.
    - `o_data` is frozen while in HOLD.
  - DRAIN: `o_ready=1`. Accepted bytes are discarded and `o_data` is unchanged.
    - Accepted byte with `i_last=1` → pulse `o_error`, go to COLLECT.
    - No frame is emitted for an overlong packet.
- `o_busy = (state!=COLLECT) || (cnt!=0)`.
- `i_ack` outside HOLD is ignored.
- `i_last` without `i_valid` is ignored.
- Reset mid-packet or mid-HOLD discards all progress.

## Timing
- Reset values: `o_ready=1` (COLLECT), `o_valid=0`, `o_error=0`, `o_busy=0`, `o_data=0`, `cnt=0`.
- `o_ready` and `o_valid` are decoded from the registered state; there is no combinational path from `i_valid` or `i_ack`.
- Latency: `o_valid` rises the cycle after the final byte is accepted.
- The cycle after `o_valid && i_ack`: `o_valid=0`, `o_ready=1`. This gives a one-cycle bubble between frames.
- Back-to-back packets are accepted at 1 byte/cycle with no bubble inside a packet.
- Gaps in `i_valid` are tolerated; `cnt` holds during gaps.
- `o_error` is registered: it is high for exactly one cycle, the cycle after the offending `i_last` byte is accepted.

## Configuration
- Macro: `TASK_8_DESER_LEN_CHECK_EN`.
- Defined: full behaviour above, including DRAIN and `o_error`.
- Undefined:
  - `i_last` is ignored, and DRAIN and the short-packet path are not built.
  - Every `BYTES` accepted bytes go to HOLD.
  - `o_error` is tied to 0.

## Test plan
- Reset, then `BYTES=16` bytes 0x00..0x0F at one per cycle, `i_last` on 0x0F, `i_ack=1` → `o_valid` for one cycle, one cycle after byte 0x0F. `o_data=0x000102030405060708090A0B0C0D0E0F`. `o_error=0`.
- Same packet with `i_ack=0` for 5 cycles, `i_valid` held high with byte 0xAA → `o_valid` and `o_data` stable and `o_ready=0` for those 5 cycles. After `i_ack`, `o_ready=1` next cycle and 0xAA is accepted as byte 0 of the next packet.
- Short packet 0x11,0x22,0x33 with `i_last` on 0x33 → `o_error` pulses once, `o_valid` never rises. A following 16-byte packet 0x10..0x1F produces `o_data=0x101112...1F`.
- Long packet of 18 bytes, `i_last` on byte 18 → no `o_valid`, `o_error` pulses once in the cycle after byte 18. `o_busy` stays high from byte 1 until the cycle after byte 18.
- 7 bytes accepted, then `i_rst` pulsed asynchronously between clock edges → `o_data=0`, `cnt=0`, `o_busy=0` immediately. A following 16-byte packet 0x20..0x2F is correct, with no residue from the first 7 bytes.
- 16-byte packet 0x30..0x3F with `i_valid` toggling every other cycle → frame `0x303132...3F` is correct. Without `TASK_8_DESER_LEN_CHECK_EN`, the 3-byte short packet from the third test is instead absorbed as the first 3 bytes of the next frame.
